// File: rtl/cdb_arbiter_if.sv
`timescale 1ns/1ps
// CDB arbiter bus: requester offers (valid/ready, tag, data), flush, and the
// registered common-data-bus broadcast. master = functional-unit/consumer side,
// slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic                      flush;      // branch-mispredict flush
  logic [NUM_REQ-1:0]        req_valid;  // requester i offers a result
  logic [NUM_REQ-1:0]        req_ready;  // requester i's offer is taken this cycle
  logic [NUM_REQ*TAG_W-1:0]  req_tag;    // slice i = [i*TAG_W +: TAG_W]
  logic [NUM_REQ*DATA_W-1:0] req_data;   // slice i = [i*DATA_W +: DATA_W]
  logic                      cdb_valid;  // broadcast valid
  logic [TAG_W-1:0]          cdb_tag;    // broadcast ROB tag
  logic [DATA_W-1:0]         cdb_data;   // broadcast value
  logic [ID_W-1:0]           grant_id;   // requester currently on the CDB

  modport master (
    output flush, req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, grant_id
  );

  modport slave (
    input  flush, req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, grant_id
  );
endinterface

// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
// Purpose: one-entry buffer per functional unit, round-robin pick of one result
//          per cycle onto a registered CDB (tag, data, grant_id).
// Latency: 2 cycles valid-in to cdb_valid (1 cycle with CDB_BYPASS_EN defined,
//          which lets an empty buffer with req_valid high compete directly).
// Backpressure: req_ready[i] = !buf_full[i] | grant[i]; all ready low during flush.
// Ports: clk, rst (async, active-high), bus (cdb_arbiter_if.slave).
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] buf_full;
  logic [TAG_W-1:0]   buf_tag  [NUM_REQ];
  logic [DATA_W-1:0]  buf_data [NUM_REQ];
  logic [ID_W-1:0]    last;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] byp;
  logic [NUM_REQ-1:0] xfer;
  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_idx;
  logic [TAG_W-1:0]   win_tag;
  logic [DATA_W-1:0]  win_data;

`ifdef CDB_BYPASS_EN
  assign cand = buf_full | bus.req_valid;
`else
  assign cand = buf_full;
`endif

  // Round-robin scan starting just after the last winner, wrapping.
  always_comb begin : p_arb
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!gnt_vld && cand[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  // Flush kills the grant so the selected buffer is neither reloaded nor sent.
  always_comb begin
    grant = '0;
    if (gnt_vld && !bus.flush) grant[gnt_idx] = 1'b1;
  end

  // A granted empty buffer is a bypass: the offer goes straight to the CDB.
  assign byp           = grant & ~buf_full;
  assign bus.req_ready = bus.flush ? '0 : (~buf_full | grant);
  assign xfer          = bus.req_valid & bus.req_ready & ~byp;

  always_comb begin
    win_tag  = buf_tag[gnt_idx];
    win_data = buf_data[gnt_idx];
`ifdef CDB_BYPASS_EN
    if (!buf_full[gnt_idx]) begin
      win_tag  = bus.req_tag[gnt_idx*TAG_W +: TAG_W];
      win_data = bus.req_data[gnt_idx*DATA_W +: DATA_W];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full      <= '0;
      last          <= LAST_RST;
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_data  <= '0;
      bus.grant_id  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_tag[i]  <= '0;
        buf_data[i] <= '0;
      end
    end else if (bus.flush) begin
      buf_full      <= '0;
      bus.cdb_valid <= 1'b0;
    end else begin
      bus.cdb_valid <= gnt_vld;
      if (gnt_vld) begin
        bus.cdb_tag  <= win_tag;
        bus.cdb_data <= win_data;
        bus.grant_id <= gnt_idx;
        last         <= gnt_idx;
      end
      // A same-cycle transfer into the granted buffer reloads it.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer[i]) begin
          buf_full[i] <= 1'b1;
          buf_tag[i]  <= bus.req_tag[i*TAG_W +: TAG_W];
          buf_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          buf_full[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) among the functional units of the Tomasulo back end (ALU, compare, load, branch) so that completed results reach the reorder buffer and reservation stations. Each requester gets a one-entry holding buffer. A round-robin arbiter picks one buffered result per cycle and drives it onto a registered CDB output. The arbiter sits between the functional-unit outputs and the `cdb` consumers (ROB, reservation stations, register file).

## Interface
Parameters:
- `NUM_REQ`, 4: number of functional-unit requesters; must be ≥2.
- `TAG_W`, 3: ROB tag width (8-entry ROB).
- `DATA_W`, 32: result width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  synchronous flush on branch mispredict.
- `req_valid`  in  NUM_REQ  requester i offers a result.
- `req_ready`  out  NUM_REQ  requester i's offer is accepted this cycle.
- `req_tag`  in  NUM_REQ*TAG_W  ROB tag per requester; slice i = bits [i*TAG_W +: TAG_W].
- `req_data`  in  NUM_REQ*DATA_W  result per requester; sliced the same way.
- `cdb_valid`  out  1  broadcast valid.
- `cdb_tag`  out  TAG_W  broadcast ROB tag.
- `cdb_data`  out  DATA_W  broadcast value.
- `grant_id`  out  $clog2(NUM_REQ)  index of the requester currently on the CDB.

## Operation
- Per-requester state:
  - `buf_full[i]`, plus the tag and data held in the buffer.
  - Single round-robin pointer `last` (the most recently granted index).
- Acceptance:
  - `req_ready[i] = !buf_full[i] | grant[i]`, where `grant[i]` means buffer i is selected this cycle.
  - A transfer occurs when `req_valid[i] & req_ready[i]`; it writes buffer i and sets `buf_full[i]`.
- Arbitration (combinational):
  - Candidates are the full buffers.
  - Scan from `last+1` upward, wrapping modulo NUM_REQ; the first candidate wins.
  - At most one grant per cycle.
  - If there are no candidates, there is no grant and `last` holds.
- Grant effects at the rising edge:
  - The winner's tag and data are registered into `cdb_tag`/`cdb_data`.
  - `cdb_valid` is set to 1 and `grant_id` is set to the winner's index.
  - `last` is set to the winner's index.
  - `buf_full[winner]` clears, unless the same requester transfers in that same cycle, in which case the buffer reloads and stays full.
- With no grant, `cdb_valid` is 0 next cycle; `cdb_tag`, `cdb_data` and `grant_id` hold.
- Fairness: a full buffer is granted within NUM_REQ cycles.
- Flush:
  - Clears all `buf_full` and `cdb_valid` at the next edge.
  - Flush dominates both the transfer and the grant in that cycle.
  - `req_ready` is forced to 0 while `flush` is high.
  - `last` is unaffected.
- Reset values:
  - `cdb_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0, `grant_id` = 0.
  - `buf_full` = all 0, `last` = NUM_REQ-1, so index 0 has first priority.
  - `req_ready` = all 1 once `rst` is low.
- Reset mid-operation: buffered results are discarded and the outputs return to their reset values immediately (asynchronous).

## Timing
- Latency: a request accepted at edge E is broadcast at earliest in the cycle following edge E+1; `cdb_valid` is high 2 cycles after `req_valid` was first sampled.
- Throughput: 1 broadcast per cycle. Each requester sustains 1 result per cycle only while it alone is requesting.
- A requester may hold `req_valid` with changing data; only the value present at the transfer edge is captured.
- `cdb_*` outputs are registered; there is no combinational path from `req_*` to `cdb_*`, except as described under Configuration.
- `req_ready` depends combinationally on `buf_full`, `last` and `flush` only, not on `req_valid`.

## Configuration
- `CDB_BYPASS_EN` defined:
  - An empty buffer with `req_valid` high is also a candidate.
  - If it wins, its `req_tag`/`req_data` go straight into the CDB registers and the buffer stays empty.
  - Minimum latency becomes 1 cycle (`cdb_valid` high the cycle after `req_valid`).
  - `req_ready` stays 1 for such requesters.
- `CDB_BYPASS_EN` undefined: only full buffers arbitrate; 2-cycle minimum latency as described under Timing.

## Test plan
- Reset then idle: assert `rst` mid-cycle, then release.
  - Outputs go to 0 asynchronously.
  - `req_ready` = 4'b1111 after release.
  - `cdb_valid` stays 0 with no requests.
- Single request: req 2 offers tag 5, data 0xDEADBEEF for one cycle.
  - `cdb_valid` = 1, `cdb_tag` = 5, `cdb_data` = 0xDEADBEEF, `grant_id` = 2, exactly 2 cycles later (1 cycle with `CDB_BYPASS_EN`).
  - `cdb_valid` = 0 the following cycle.
- Round-robin, all 4 requesters hold `req_valid` continuously with tags 0–3.
  - Grant order 0,1,2,3,0,1,… from reset.
  - No requester waits more than 4 cycles.
  - `cdb_valid` is high every cycle after the first two.
- Back-pressure: req 1 offers A then B while req 0 and req 3 keep their buffers full.
  - `req_ready[1]` = 0 while A is buffered.
  - B is accepted in the cycle A is granted.
  - A is broadcast before B; no result is lost or duplicated.
- Flush: flush raised while buffers 0 and 2 are full and `cdb_valid` = 1.
  - Next cycle `cdb_valid` = 0 and `req_ready` = 4'b1111.
  - No flushed tag ever appears on the CDB.
- Wrap-around: with `last` = 3, requesters 3 and 0 both full.
  - Requester 0 is granted first, then requester 3.
